idex_pipe_reg: RTL

- Parametrised ID/EX pipeline register: successor to the fixed two-deep ID/EX buffer.
- Carries EX/MEM control fields, two register-read operands, destination register and immediate from decode to execute through DEPTH register stages.
- Adds async reset, per-stage valid bit, stall (hold), flush (bubble insertion), explicit immediate narrowing and a saturating bubble counter for performance monitoring.

---
 rtl/idex_pkg.sv | 21 ++
 rtl/idex_pipe_reg_if.sv | 39 +++
 rtl/idex_stage_cell.sv | 23 ++
 rtl/idex_pipe_reg.sv | 81 ++++++++
 4 files changed

// File: rtl/idex_pkg.sv
// rtl/idex_pkg.sv - default widths and stage record for the ID/EX pipeline register
package idex_pkg;

  localparam int EX_W_DEF   = 4;
  localparam int MEM_W_DEF  = 7;
  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;
  localparam int IMM_W_DEF  = 32;

  // One pipeline slot at default widths.
  typedef struct packed {
    logic                  valid;
    logic [EX_W_DEF-1:0]   ex;
    logic [MEM_W_DEF-1:0]  mem;
    logic [DATA_W_DEF-1:0] rd1;
    logic [DATA_W_DEF-1:0] rd2;
    logic [REG_W_DEF-1:0]  rd;
    logic [IMM_W_DEF-1:0]  imm;
  } idex_stage_t;

endpackage

// File: rtl/idex_pipe_reg_if.sv
// rtl/idex_pipe_reg_if.sv - decode-side inputs and execute-side outputs of the ID/EX register
interface idex_pipe_reg_if #(
  parameter int EX_W      = 4,
  parameter int MEM_W     = 7,
  parameter int DATA_W    = 32,
  parameter int REG_W     = 5,
  parameter int IMM_IN_W  = 32,
  parameter int IMM_OUT_W = 16,
  parameter int CNT_W     = 16
);

  logic                 i_valid;
  logic [EX_W-1:0]      i_ex;
  logic [MEM_W-1:0]     i_mem;
  logic [DATA_W-1:0]    i_rd1;
  logic [DATA_W-1:0]    i_rd2;
  logic [REG_W-1:0]     i_rd;
  logic [IMM_IN_W-1:0]  i_imm;

  logic                 o_valid;
  logic [EX_W-1:0]      o_ex;
  logic [MEM_W-1:0]     o_mem;
  logic [DATA_W-1:0]    o_rd1;
  logic [DATA_W-1:0]    o_rd2;
  logic [REG_W-1:0]     o_rd;
  logic [IMM_OUT_W-1:0] o_imm;
  logic [CNT_W-1:0]     o_bubbles;

  modport master (
    output i_valid, i_ex, i_mem, i_rd1, i_rd2, i_rd, i_imm,
    input  o_valid, o_ex, o_mem, o_rd1, o_rd2, o_rd, o_imm, o_bubbles
  );

  modport slave (
    input  i_valid, i_ex, i_mem, i_rd1, i_rd2, i_rd, i_imm,
    output o_valid, o_ex, o_mem, o_rd1, o_rd2, o_rd, o_imm, o_bubbles
  );

endinterface

// File: rtl/idex_stage_cell.sv
// rtl/idex_stage_cell.sv - one pipeline stage with reset > flush > stall > load priority
module idex_stage_cell #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         stall,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/idex_pipe_reg.sv
// rtl/idex_pipe_reg.sv - DEPTH-stage ID/EX register with stall, flush, imm narrowing and bubble counter
module idex_pipe_reg
  import idex_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int EX_W      = EX_W_DEF,
  parameter int MEM_W     = MEM_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int REG_W     = REG_W_DEF,
  parameter int IMM_IN_W  = IMM_W_DEF,
  parameter int IMM_OUT_W = 16,
  parameter int CNT_W     = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  idex_pipe_reg_if.slave  bus
);

  localparam int PW = 1 + EX_W + MEM_W + 2 * DATA_W + REG_W + IMM_IN_W;

  logic [DEPTH-1:0][PW-1:0] stage_q;
  logic [PW-1:0]            in_word;
  logic                     out_valid;
  logic [IMM_IN_W-1:0]      out_imm;
  logic [CNT_W-1:0]         bubbles_q;

  // Bubbles carry zero control so execute never acts on them.
  assign in_word = {bus.i_valid,
                    bus.i_ex  & {EX_W{bus.i_valid}},
                    bus.i_mem & {MEM_W{bus.i_valid}},
                    bus.i_rd1, bus.i_rd2, bus.i_rd, bus.i_imm};

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_first
        idex_stage_cell #(.W(PW)) u_cell (
          .clock (clock),
          .reset (reset),
          .stall (stall),
          .flush (flush),
          .d     (in_word),
          .q     (stage_q[k])
        );
      end else begin : g_next
        idex_stage_cell #(.W(PW)) u_cell (
          .clock (clock),
          .reset (reset),
          .stall (stall),
          .flush (flush),
          .d     (stage_q[k-1]),
          .q     (stage_q[k])
        );
      end
    end
  endgenerate

  assign {out_valid, bus.o_ex, bus.o_mem, bus.o_rd1, bus.o_rd2, bus.o_rd, out_imm} = stage_q[DEPTH-1];
  assign bus.o_valid = out_valid;
  assign bus.o_imm   = out_imm[IMM_OUT_W-1:0];

  generate
    if (IMM_OUT_W < IMM_IN_W) begin : g_imm_hi
      logic unused_imm_hi;
      assign unused_imm_hi = ^out_imm[IMM_IN_W-1:IMM_OUT_W];
    end
  endgenerate

  // Saturating count of empty output cycles, including stalled ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bubbles_q <= '0;
    end else if (!out_valid && (bubbles_q != {CNT_W{1'b1}})) begin
      bubbles_q <= bubbles_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.o_bubbles = bubbles_q;

endmodule
